// File: rtl/clause_scan_scheduler_pkg.sv
// Shared BCP definitions: clause-store geometry, the implication record handed
// to the trail unit, and the clause scan scheduler state encoding.
package bcp_pkg;

    localparam int NUM_CLAUSES = 512;
    localparam int CLAUSE_AW   = 9;
    localparam int VAR_W       = 9;

    typedef struct packed {
        logic [VAR_W-1:0] var_idx;
        logic             value;
    } impl_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN,
        DONE
    } sched_state_t;

endpackage

// File: rtl/clause_scan_scheduler_if.sv
// Scheduler-facing bundle: pass control, evaluation pipe issue/return and the
// implication stream towards the trail unit.
interface clause_scan_scheduler_if #(
    parameter int CLAUSE_AW = bcp_pkg::CLAUSE_AW,
    parameter int VAR_W     = bcp_pkg::VAR_W
);

    logic                 start;
    logic                 busy;
    logic                 done;
    logic                 conflict;
    logic [CLAUSE_AW-1:0] conflict_clause;

    logic                 issue_valid;
    logic [CLAUSE_AW-1:0] issue_addr;
    logic                 res_valid;
    logic [CLAUSE_AW-1:0] res_addr;
    logic                 res_unit;
    logic                 res_conflict;
    logic [VAR_W-1:0]     res_var;
    logic                 res_value;

    logic                 impl_valid;
    logic                 impl_ready;
    logic [VAR_W-1:0]     impl_var;
    logic                 impl_value;

    modport master (
        input  start,
        output busy, done, conflict, conflict_clause,
        output issue_valid, issue_addr,
        input  res_valid, res_addr, res_unit, res_conflict, res_var, res_value,
        output impl_valid, impl_var, impl_value,
        input  impl_ready
    );

    modport slave (
        output start,
        input  busy, done, conflict, conflict_clause,
        input  issue_valid, issue_addr,
        output res_valid, res_addr, res_unit, res_conflict, res_var, res_value,
        input  impl_valid, impl_var, impl_value,
        output impl_ready
    );

endinterface

// File: rtl/clause_scan_scheduler_fifo.sv
// Synchronous FIFO with occupancy count; the head entry is read straight from
// storage so consecutive pops need no bubble.
module impl_fifo #(
    parameter type entry_t = logic [7:0],
    parameter int  DEPTH   = 8,
    localparam int AW      = $clog2(DEPTH),
    localparam int CW      = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  entry_t        push_data,
    input  logic          pop,
    output entry_t        head,
    output logic          empty,
    output logic [CW-1:0] count
);

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // NOTE: storage carries no reset; validity is tracked by count alone, which keeps the array as plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/clause_scan_scheduler.sv
// Walks the clause store once per BCP pass, feeding the fixed-latency evaluation
// pipe under a credit limit and queueing unit implications for the trail unit.
module clause_scan_scheduler #(
    parameter int NUM_CLAUSES = bcp_pkg::NUM_CLAUSES,
    parameter int CLAUSE_AW   = bcp_pkg::CLAUSE_AW,
    parameter int VAR_W       = bcp_pkg::VAR_W,
    parameter int EVAL_LAT    = 2,
    parameter int FIFO_DEPTH  = 8
) (
    input logic                     clk,
    input logic                     rst_n,
    clause_scan_scheduler_if.master bus
);
    import bcp_pkg::*;

    localparam int                   CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CLAUSE_AW-1:0] LAST_ADDR = CLAUSE_AW'(NUM_CLAUSES - 1);

    if ((1 << CLAUSE_AW) < NUM_CLAUSES || FIFO_DEPTH < EVAL_LAT + 1 || VAR_W != bcp_pkg::VAR_W)
    begin : g_bad_params
        $error("clause_scan_scheduler: inconsistent parameters");
    end

    sched_state_t         state;
    sched_state_t         state_next;
    logic [CLAUSE_AW-1:0] issue_ptr;
    logic [CNT_W-1:0]     inflight;
    logic [CNT_W-1:0]     fifo_count;
    logic [CNT_W:0]       occupancy;
    logic                 conflict_q;
    logic [CLAUSE_AW-1:0] conflict_clause_q;
    impl_t                fifo_head;
    impl_t                push_data;
    logic                 fifo_empty;
    logic                 fifo_drained;
    logic                 res_take;
    logic                 res_conf;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 credit_ok;
    logic                 issue_fire;
    logic                 start_accept;

    // Results count only while a pass has clauses outstanding; stray returns are dropped.
    assign res_take     = bus.res_valid && (inflight != '0) && (state == SCAN || state == DRAIN);
    assign res_conf     = res_take && bus.res_conflict;
    assign fifo_push    = res_take && bus.res_unit && !bus.res_conflict;
    assign fifo_pop     = !fifo_empty && bus.impl_ready;
    assign push_data    = '{var_idx: bus.res_var, value: bus.res_value};
    assign start_accept = (state == IDLE) && bus.start;

    // Every clause in flight has a reserved FIFO slot because the pipe cannot stall.
    assign occupancy  = {1'b0, fifo_count} + {1'b0, inflight};
    assign credit_ok  = occupancy < (CNT_W + 1)'(FIFO_DEPTH);
    assign issue_fire = (state == SCAN) && credit_ok && !res_conf;

    // The last pop can coincide with leaving DRAIN, so DONE is not delayed by a cycle.
    assign fifo_drained = fifo_empty || (fifo_count == CNT_W'(1) && fifo_pop);

    impl_fifo #(
        .entry_t (impl_t),
        .DEPTH   (FIFO_DEPTH)
    ) u_impl_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (push_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: the default assignment up front keeps this combinational block free of inferred latches.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = SCAN;
            SCAN:    if (res_conf || (issue_fire && issue_ptr == LAST_ADDR)) state_next = DRAIN;
            DRAIN:   if (inflight == '0 && fifo_drained) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.issue_valid     = issue_fire;
        bus.issue_addr      = issue_ptr;
        bus.busy            = (state == SCAN) || (state == DRAIN);
        bus.done            = (state == DONE);
        bus.conflict        = conflict_q;
        bus.conflict_clause = conflict_clause_q;
        bus.impl_valid      = !fifo_empty;
        bus.impl_var        = fifo_head.var_idx;
        bus.impl_value      = fifo_head.value;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_ptr         <= '0;
            inflight          <= '0;
            conflict_q        <= 1'b0;
            conflict_clause_q <= '0;
        end else begin
            if (start_accept)    issue_ptr <= '0;
            else if (issue_fire) issue_ptr <= issue_ptr + 1'b1;

            case ({issue_fire, res_take})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase

            // Only the first conflict of a pass is reported.
            if (start_accept) begin
                conflict_q        <= 1'b0;
                conflict_clause_q <= '0;
            end else if (res_conf && !conflict_q) begin
                conflict_q        <= 1'b1;
                conflict_clause_q <= bus.res_addr;
            end
        end
    end

endmodule

// File: tb/tb_clause_scan_scheduler.sv
// Randomised bench for clause_scan_scheduler: a delay-line evaluation pipe driven
// from per-clause tables, and a reference built from the observed issue order.
module tb_clause_scan_scheduler;

    localparam int N     = 16;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;
    localparam int AW    = bcp_pkg::CLAUSE_AW;
    localparam int VW    = bcp_pkg::VAR_W;
    localparam int IW    = $clog2(N);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    clause_scan_scheduler_if #(.CLAUSE_AW(AW), .VAR_W(VW)) bus ();

    clause_scan_scheduler #(
        .NUM_CLAUSES (N),
        .CLAUSE_AW   (AW),
        .VAR_W       (VW),
        .EVAL_LAT    (LAT),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // Clause contents as seen by the evaluation pipe.
    logic          unit_tab [N];
    logic          conf_tab [N];
    logic [VW-1:0] var_tab  [N];
    logic          val_tab  [N];

    logic          pipe_v [LAT];
    logic [AW-1:0] pipe_a [LAT];
    logic [IW-1:0] res_idx;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) begin
                pipe_v[i] <= 1'b0;
                pipe_a[i] <= '0;
            end
        end else begin
            pipe_v[0] <= bus.issue_valid;
            pipe_a[0] <= bus.issue_addr;
            for (int i = 1; i < LAT; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_a[i] <= pipe_a[i-1];
            end
        end
    end

    assign res_idx          = pipe_a[LAT-1][IW-1:0];
    assign bus.res_valid    = pipe_v[LAT-1];
    assign bus.res_addr     = pipe_a[LAT-1];
    assign bus.res_unit     = pipe_v[LAT-1] && unit_tab[res_idx];
    assign bus.res_conflict = pipe_v[LAT-1] && conf_tab[res_idx];
    assign bus.res_var      = var_tab[res_idx];
    assign bus.res_value    = val_tab[res_idx];

    // 0: hold low, 1: hold high, 2: random each cycle
    int ready_mode = 0;
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       bus.impl_ready = 1'b0;
            1:       bus.impl_ready = 1'b1;
            default: bus.impl_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Observation of one pass
    logic [AW-1:0] issued_q [$];
    logic [VW:0]   got_q    [$];
    logic [VW:0]   exp_q    [$];
    int            exp_conf;
    int            n_iss, n_ret, n_push, n_pop, late_issue, occ_viol;
    bit            conf_seen;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.issue_valid && (conf_seen || (bus.res_valid && bus.res_conflict))) late_issue++;
            if (bus.res_valid) begin
                n_ret++;
                if (bus.res_conflict)      conf_seen = 1'b1;
                else if (bus.res_unit)     n_push++;
            end
            if (bus.issue_valid) begin
                issued_q.push_back(bus.issue_addr);
                n_iss++;
            end
            if (bus.impl_valid && bus.impl_ready) begin
                got_q.push_back({bus.impl_var, bus.impl_value});
                n_pop++;
            end
            if ((n_iss - n_ret) + (n_push - n_pop) > DEPTH) occ_viol++;
            assert (!bus.res_valid || bus.busy) else $error("protocol: result returned while scheduler idle");
        end
    end

    // Expected stream: units among issued clauses, in issue order, skipping conflicting ones.
    function automatic int impl_diffs();
        int d = 0;
        exp_q    = {};
        exp_conf = -1;
        foreach (issued_q[i]) begin
            int a = int'(issued_q[i]);
            if (a >= N) d++;
            else if (conf_tab[a]) begin
                if (exp_conf < 0) exp_conf = a;
            end else if (unit_tab[a]) exp_q.push_back({var_tab[a], val_tab[a]});
        end
        if (got_q.size() != exp_q.size()) d += 1000;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] !== exp_q[i]) d++;
        return d;
    endfunction

    function automatic int order_errs();
        int d = 0;
        foreach (issued_q[i]) if (int'(issued_q[i]) != i) d++;
        return d;
    endfunction

    task automatic fill_tables(input int unit_pct);
        for (int i = 0; i < N; i++) begin
            unit_tab[i] = ($urandom_range(0, 99) < unit_pct);
            conf_tab[i] = 1'b0;
            var_tab[i]  = VW'($urandom_range(0, (1 << VW) - 1));
            val_tab[i]  = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic start_pass();
        @(posedge clk);
        #1;
        issued_q = {}; got_q = {};
        n_iss = 0; n_ret = 0; n_push = 0; n_pop = 0;
        late_issue = 0; occ_viol = 0; conf_seen = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // lat = number of edges after the one that sampled start; -1 on timeout
    task automatic wait_done(input int max_cycles, output int lat, output bit busy_ok);
        lat = -1;
        busy_ok = 1'b1;
        for (int k = 1; k <= max_cycles; k++) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            if (bus.done) begin
                lat = k;
                if (bus.busy) busy_ok = 1'b0;
                break;
            end
            if (!bus.busy) busy_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        ready_mode = 0;
        bus.start = 1'b0;
        bus.impl_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if (bus.issue_valid !== 1'b0) begin errors++; $display("FAIL reset_issue_valid got=%b exp=0", bus.issue_valid); end
        checks++; if (bus.issue_addr !== '0) begin errors++; $display("FAIL reset_issue_addr got=%0d exp=0", bus.issue_addr); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        checks++; if (bus.conflict !== 1'b0) begin errors++; $display("FAIL reset_conflict got=%b exp=0", bus.conflict); end
        checks++; if (bus.conflict_clause !== '0) begin errors++; $display("FAIL reset_conflict_clause got=%0d exp=0", bus.conflict_clause); end
        checks++; if (bus.impl_valid !== 1'b0) begin errors++; $display("FAIL reset_impl_valid got=%b exp=0", bus.impl_valid); end
    endtask

    task automatic test_basic();
        int lat; bit busy_ok; int d;
        fill_tables(0);
        unit_tab[1] = 1'b1; var_tab[1] = VW'(7); val_tab[1] = 1'b1;
        unit_tab[3] = 1'b1; var_tab[3] = VW'(2); val_tab[3] = 1'b0;
        ready_mode = 1;
        start_pass();
        wait_done(200, lat, busy_ok);
        checks++; if (lat != N + LAT + 1) begin errors++; $display("FAIL basic_latency got=%0d exp=%0d", lat, N + LAT + 1); end
        checks++; if (!busy_ok) begin errors++; $display("FAIL basic_busy got=0 exp=1 during pass, 0 at done"); end
        checks++; if (bus.conflict !== 1'b0) begin errors++; $display("FAIL basic_conflict got=%b exp=0", bus.conflict); end
        d = impl_diffs();
        checks++; if (d != 0 || got_q.size() != 2) begin errors++; $display("FAIL basic_impls diffs=%0d got_n=%0d exp_n=2", d, got_q.size()); end
        checks++; if (order_errs() != 0 || n_iss != N) begin errors++; $display("FAIL basic_issue_order errs=%0d issued=%0d exp=%0d", order_errs(), n_iss, N); end
        @(negedge clk);
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got=%b exp=0", bus.done); end
    endtask

    task automatic test_backpressure();
        int lat; bit busy_ok; int d;
        fill_tables(100);
        ready_mode = 0;
        @(posedge clk);
        start_pass();
        repeat (20) @(negedge clk);
        #1;
        checks++; if (n_iss != DEPTH) begin errors++; $display("FAIL bp_issue_limit got=%0d exp=%0d", n_iss, DEPTH); end
        checks++; if (bus.impl_valid !== 1'b1 || bus.issue_valid !== 1'b0) begin errors++; $display("FAIL bp_stall impl_valid=%b issue_valid=%b exp=1/0", bus.impl_valid, bus.issue_valid); end
        // a start while busy must not restart the scan
        @(posedge clk); #1; bus.start = 1'b1;
        @(posedge clk); #1; bus.start = 1'b0;
        ready_mode = 1;
        wait_done(300, lat, busy_ok);
        checks++; if (lat < 0) begin errors++; $display("FAIL bp_timeout got=no done exp=done"); end
        d = impl_diffs();
        checks++; if (d != 0 || n_pop != N) begin errors++; $display("FAIL bp_impls diffs=%0d popped=%0d exp=%0d", d, n_pop, N); end
        checks++; if (occ_viol != 0 || order_errs() != 0) begin errors++; $display("FAIL bp_credit over_depth=%0d order_errs=%0d exp=0", occ_viol, order_errs()); end
    endtask

    task automatic test_conflict();
        int lat; bit busy_ok; int d;
        fill_tables(0);
        unit_tab[2] = 1'b1; var_tab[2] = VW'(20); val_tab[2] = 1'b1;
        conf_tab[5] = 1'b1;
        unit_tab[5] = 1'b1;
        unit_tab[6] = 1'b1; var_tab[6] = VW'(301); val_tab[6] = 1'b0;
        ready_mode = 1;
        start_pass();
        wait_done(200, lat, busy_ok);
        checks++; if (lat < 0 || bus.conflict !== 1'b1) begin errors++; $display("FAIL conf_flag lat=%0d got=%b exp=1", lat, bus.conflict); end
        checks++; if (bus.conflict_clause !== AW'(5)) begin errors++; $display("FAIL conf_clause got=%0d exp=5", bus.conflict_clause); end
        checks++; if (n_iss != 5 + LAT || late_issue != 0) begin errors++; $display("FAIL conf_issue_stop issued=%0d exp=%0d late=%0d", n_iss, 5 + LAT, late_issue); end
        d = impl_diffs();
        checks++; if (d != 0 || got_q.size() != 2) begin errors++; $display("FAIL conf_impls diffs=%0d got_n=%0d exp_n=2", d, got_q.size()); end
        repeat (3) @(negedge clk);
        checks++; if (bus.conflict_clause !== AW'(5)) begin errors++; $display("FAIL conf_clause_hold got=%0d exp=5", bus.conflict_clause); end
    endtask

    task automatic test_back_to_back();
        int lat; bit busy_ok; int d;
        fill_tables(50);
        conf_tab[3] = 1'b1;
        conf_tab[4] = 1'b1;
        ready_mode = 2;
        start_pass();
        wait_done(400, lat, busy_ok);
        checks++; if (lat < 0 || bus.conflict_clause !== AW'(3)) begin errors++; $display("FAIL dbl_conf_clause lat=%0d got=%0d exp=3", lat, bus.conflict_clause); end
        d = impl_diffs();
        checks++; if (d != 0 || late_issue != 0) begin errors++; $display("FAIL dbl_conf_impls diffs=%0d late=%0d exp=0", d, late_issue); end
        // immediately following clean pass clears the conflict report
        fill_tables(60);
        start_pass();
        wait_done(400, lat, busy_ok);
        checks++; if (lat < 0 || bus.conflict !== 1'b0 || bus.conflict_clause !== '0) begin errors++; $display("FAIL b2b_clear lat=%0d conflict=%b clause=%0d exp=0/0", lat, bus.conflict, bus.conflict_clause); end
        d = impl_diffs();
        checks++; if (d != 0 || n_iss != N) begin errors++; $display("FAIL b2b_impls diffs=%0d issued=%0d exp=%0d", d, n_iss, N); end
    endtask

    task automatic test_wrap();
        int lat; bit busy_ok; int d;
        for (int p = 0; p < 2; p++) begin
            fill_tables(100);
            ready_mode = 2;
            start_pass();
            wait_done(400, lat, busy_ok);
            d = impl_diffs();
            checks++; if (lat < 0 || d != 0 || n_pop != N) begin errors++; $display("FAIL wrap_pass%0d lat=%0d diffs=%0d popped=%0d exp=%0d", p, lat, d, n_pop, N); end
            checks++; if (occ_viol != 0) begin errors++; $display("FAIL wrap_credit%0d over_depth=%0d exp=0", p, occ_viol); end
        end
    endtask

    task automatic test_random();
        int lat; bit busy_ok; int d;
        for (int p = 0; p < 4; p++) begin
            fill_tables(40);
            if (p[0]) conf_tab[$urandom_range(0, N - 1)] = 1'b1;
            ready_mode = 2;
            start_pass();
            wait_done(400, lat, busy_ok);
            d = impl_diffs();
            checks++; if (lat < 0 || d != 0) begin errors++; $display("FAIL rand%0d_impls lat=%0d diffs=%0d", p, lat, d); end
            checks++; if (bus.conflict !== (exp_conf >= 0)) begin errors++; $display("FAIL rand%0d_conflict got=%b exp=%b", p, bus.conflict, exp_conf >= 0); end
            checks++; if (exp_conf >= 0 && bus.conflict_clause !== AW'(exp_conf)) begin errors++; $display("FAIL rand%0d_clause got=%0d exp=%0d", p, bus.conflict_clause, exp_conf); end
            checks++; if (late_issue != 0 || occ_viol != 0 || order_errs() != 0) begin errors++; $display("FAIL rand%0d_issue late=%0d over=%0d order=%0d exp=0", p, late_issue, occ_viol, order_errs()); end
        end
    endtask

    task automatic test_reset_mid();
        int lat; bit busy_ok; int d; bit hit;
        fill_tables(100);
        ready_mode = 1;
        start_pass();
        hit = 1'b0;
        for (int k = 0; k < 60 && !hit; k++) begin
            @(negedge clk);
            if (bus.issue_valid && bus.issue_addr == AW'(9)) hit = 1'b1;
        end
        checks++; if (!hit) begin errors++; $display("FAIL rst_mid_reach got=no issue of 9 exp=issue of 9"); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.issue_valid, bus.issue_addr, bus.busy, bus.done, bus.conflict, bus.conflict_clause, bus.impl_valid} !== '0) begin
            errors++;
            $display("FAIL rst_mid_async iv=%b ia=%0d busy=%b done=%b conf=%b cc=%0d impl_v=%b exp=all 0",
                     bus.issue_valid, bus.issue_addr, bus.busy, bus.done, bus.conflict, bus.conflict_clause, bus.impl_valid);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        fill_tables(50);
        start_pass();
        wait_done(200, lat, busy_ok);
        d = impl_diffs();
        checks++; if (lat != N + LAT + 1 || d != 0 || n_iss != N) begin errors++; $display("FAIL rst_mid_fresh lat=%0d exp=%0d diffs=%0d issued=%0d", lat, N + LAT + 1, d, n_iss); end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.impl_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            unit_tab[i] = 1'b0; conf_tab[i] = 1'b0; var_tab[i] = '0; val_tab[i] = 1'b0;
        end
        test_reset();
        test_basic();
        test_backpressure();
        test_conflict();
        test_back_to_back();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clause_scan_scheduler.md
Name: clause_scan_scheduler

Overview:
- Sequences the sub-clause evaluation datapath over the clause store during one Boolean constraint propagation (BCP) pass.
- Walks clause addresses, issues them into the fixed-latency evaluation pipe (clause fetch + sub-clause evaluator), and collects returned unit implications into an internal FIFO.
- Drains implications to the assignment/trail unit over a valid/ready handshake.
- Stops the pass early on a clause conflict and reports the offending clause index.

Parameters:
- NUM_CLAUSES, 512: clauses per scan; addresses 0..NUM_CLAUSES-1.
- CLAUSE_AW, 9: clause address width; must satisfy 2^CLAUSE_AW >= NUM_CLAUSES.
- VAR_W, 9: variable index width.
- EVAL_LAT, 2: cycles from issue to result at the scheduler inputs, fixed, >= 1.
- FIFO_DEPTH, 8: implication FIFO entries; power of two, >= EVAL_LAT+1.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a pass; ignored unless in IDLE.
- busy  out  1  high from the cycle after accepted start until DONE is entered.
- done  out  1  one-cycle pulse on DONE entry.
- conflict  out  1  valid with done; 1 if the pass ended on a conflict.
- conflict_clause  out  CLAUSE_AW  index of the first conflicting clause; held until the next start.
- issue_valid  out  1  clause address presented to the evaluation pipe this cycle.
- issue_addr  out  CLAUSE_AW  clause address.
- res_valid  in  1  result valid; asserted exactly EVAL_LAT cycles after each issue.
- res_addr  in  CLAUSE_AW  echoed clause address.
- res_unit  in  1  clause is unit.
- res_conflict  in  1  clause is falsified (all masked literals assigned false).
- res_var  in  VAR_W  implied variable index.
- res_value  in  1  implied value.
- impl_valid  out  1  FIFO head valid.
- impl_ready  in  1  consumer accepts.
- impl_var  out  VAR_W  head variable index.
- impl_value  out  1  head value.

Behaviour:
- Reset values: state=IDLE; issue_valid=0, issue_addr=0, busy=0, done=0, conflict=0, conflict_clause=0, impl_valid=0; FIFO empty, all counters 0.
- States:
  - IDLE: on start, go to SCAN; clear issue pointer, conflict and conflict_clause.
  - SCAN: issue one clause per cycle when credit allows; after address NUM_CLAUSES-1 issues, go to DRAIN.
  - DRAIN: no issue; wait until in-flight=0 and FIFO empty, then go to DONE.
  - DONE: pulse done for one cycle, then go to IDLE.
- Credit rule: issue only when fifo_count + inflight + 1 <= FIFO_DEPTH. This guarantees a returning result always has FIFO space, since the pipe cannot be stalled.
  - inflight increments on issue and decrements on res_valid; simultaneous issue and return leaves it unchanged.
- Result handling:
  - res_unit=1, res_conflict=0: push {res_var, res_value}.
  - res_unit=0, res_conflict=0: discard.
  - res_conflict=1: takes priority over res_unit; no push.
- Conflict:
  - On the first res_conflict in a pass, latch conflict=1 and conflict_clause=res_addr.
  - Issuing stops that same cycle; SCAN goes to DRAIN.
  - Later results: implications are still pushed; later conflicts do not overwrite the latched index.
  - The FIFO still drains to the consumer before DONE.
- FIFO: push and pop in the same cycle are both honoured (count unchanged); pop only when impl_valid && impl_ready; pointers wrap modulo FIFO_DEPTH.
- impl_* outputs reflect the FIFO head combinationally from registers; no bubble on back-to-back pops.
- start asserted outside IDLE: ignored. res_valid while in IDLE: protocol error; assertion in the bench, ignored by RTL.
- Reset mid-pass: returns to reset values immediately. Results that arrive after reset deassertion are ignored because inflight=0 and the state is IDLE.
- Minimum pass latency with no conflict and impl_ready held high: NUM_CLAUSES + EVAL_LAT + 1 cycles from start to done.

Decomposition:
- Shared package bcp_pkg holds:
  - the constants NUM_CLAUSES, CLAUSE_AW, VAR_W;
  - typedef impl_t {var index, value}, also used by the trail unit;
  - enum sched_state_t {IDLE, SCAN, DRAIN, DONE}.
- One sub-module: impl_fifo, a parameterised synchronous FIFO with count output, instantiated once with impl_t entries.

Test Plan:
1. Small-size run (override NUM_CLAUSES=4, EVAL_LAT=2, FIFO_DEPTH=8): start; model returns unit on clause 1 (var 7, value 1) and clause 3 (var 2, value 0); impl_ready=1 -> issue_addr 0,1,2,3 on consecutive cycles; impl outputs (7,1) then (2,0); done at start+7 with conflict=0.
2. Backpressure (NUM_CLAUSES=16, FIFO_DEPTH=4, every clause unit): hold impl_ready=0 -> at most 4 issues, then issue_valid stays 0 and fifo_count plus inflight never exceeds 4; release impl_ready -> all 16 implications delivered in address order; done.
3. Conflict (NUM_CLAUSES=16): conflict on clause 5, unit on clause 6 (in flight) -> no issue after the cycle clause 5 returns; clause 6 implication still delivered; done with conflict=1, conflict_clause=5.
4. Double conflict on clauses 3 and 4 (back-to-back) -> conflict_clause=3.
5. Simultaneous push and pop with the FIFO at FIFO_DEPTH-1 -> count unchanged, no overflow; wrap across depth verified over 20 entries.
6. Assert rst_n low in SCAN at clause 9 -> all outputs at reset values asynchronously; a fresh start completes normally with correct implications.
